// File: rtl/alu_seq.sv
// alu_seq: sequences ARM-style data-processing operations through an external
// 32-bit ALU. Narrow operations take one ALU pass and wide operations take two,
// with the carry chained between them. Results are returned through a
// ready/valid writeback port, and the architectural NZCV flags are kept here.
module alu_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_cond,
   input  logic [3:0]  in_opcode,
   input  logic        in_s,
   input  logic        in_wide,
   input  logic [3:0]  in_rd,
   input  logic [63:0] in_a,
   input  logic [63:0] in_b,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic        alu_carry,
   output logic [3:0]  alu_opcode,
   input  logic [31:0] alu_c,
   input  logic [3:0]  alu_flags,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [3:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic [3:0]  flags,
   output logic        busy
);

   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_RSB = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_ADC = 4'h5;
   localparam logic [3:0] OP_SBC = 4'h6;
   localparam logic [3:0] OP_RSC = 4'h7;
   localparam logic [3:0] OP_CMP = 4'hA;
   localparam logic [3:0] OP_CMN = 4'hB;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      EXLO = 3'd1,
      EXHI = 3'd2,
      WBLO = 3'd3,
      WBHI = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  opcode_q, opcode_d;
   logic        s_q, s_d;
   logic        wide_q, wide_d;
   logic [3:0]  rd_q, rd_d;
   logic [63:0] a_q, a_d;
   logic [63:0] b_q, b_d;
   logic [31:0] res_lo_q, res_lo_d;
   logic [31:0] res_hi_q, res_hi_d;
   logic        z_lo_q, z_lo_d;
   logic        c_lo_q, c_lo_d;
   logic [3:0]  flags_q, flags_d;
   logic        upd_s;

   // ARM condition evaluation against NZCV
   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v;
      n = nzcv[3];
      z = nzcv[2];
      c = nzcv[1];
      v = nzcv[0];
      case (cond)
         4'h0:    cond_pass = z;
         4'h1:    cond_pass = !z;
         4'h2:    cond_pass = c;
         4'h3:    cond_pass = !c;
         4'h4:    cond_pass = n;
         4'h5:    cond_pass = !n;
         4'h6:    cond_pass = v;
         4'h7:    cond_pass = !v;
         4'h8:    cond_pass = c && !z;
         4'h9:    cond_pass = !c || z;
         4'hA:    cond_pass = (n == v);
         4'hB:    cond_pass = (n != v);
         4'hC:    cond_pass = !z && (n == v);
         4'hD:    cond_pass = z || (n != v);
         4'hE:    cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   endfunction

   // TST/TEQ/CMP/CMN: flags only, no writeback
   function automatic logic is_compare(input logic [3:0] op);
      is_compare = (op[3:2] == 2'b10);
   endfunction

   // Opcodes whose ALU pass produces meaningful C and V
   function automatic logic is_arith(input logic [3:0] op);
      is_arith = ((op >= OP_SUB) && (op <= OP_RSC)) || (op == OP_CMP) || (op == OP_CMN);
   endfunction

   // Upper-word opcode so the carry propagates from the lower pass
   function automatic logic [3:0] hi_opcode(input logic [3:0] op);
      case (op)
         OP_ADD, OP_CMN: hi_opcode = OP_ADC;
         OP_SUB, OP_CMP: hi_opcode = OP_SBC;
         OP_RSB:         hi_opcode = OP_RSC;
         default:        hi_opcode = op;
      endcase
   endfunction

   // Logical ops keep the previous C and V
   function automatic logic [3:0] flags_after(input logic [3:0] op, input logic [3:0] res,
                                              input logic [3:0] old);
      if (is_arith(op)) begin
         flags_after = res;
      end else begin
         flags_after = {res[3:2], old[1:0]};
      end
   endfunction

   // State and datapath registers; reset discards any operation in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         opcode_q <= 4'd0;
         s_q      <= 1'b0;
         wide_q   <= 1'b0;
         rd_q     <= 4'd0;
         a_q      <= 64'd0;
         b_q      <= 64'd0;
         res_lo_q <= 32'd0;
         res_hi_q <= 32'd0;
         z_lo_q   <= 1'b0;
         c_lo_q   <= 1'b0;
         flags_q  <= 4'd0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         s_q      <= s_d;
         wide_q   <= wide_d;
         rd_q     <= rd_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_lo_q <= res_lo_d;
         res_hi_q <= res_hi_d;
         z_lo_q   <= z_lo_d;
         c_lo_q   <= c_lo_d;
         flags_q  <= flags_d;
      end
   end

   // Next-state, operand latching, result capture and flag update
   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      s_d      = s_q;
      wide_d   = wide_q;
      rd_d     = rd_q;
      a_d      = a_q;
      b_d      = b_q;
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;
      z_lo_d   = z_lo_q;
      c_lo_d   = c_lo_q;
      flags_d  = flags_q;
      upd_s    = s_q || is_compare(opcode_q);
      case (state_q)
         IDLE: begin
            // a failed condition retires here: nothing latched, flags untouched
            if (in_valid && cond_pass(in_cond, flags_q)) begin
               opcode_d = in_opcode;
               s_d      = in_s;
               wide_d   = in_wide;
               rd_d     = in_rd;
               a_d      = in_a;
               b_d      = in_b;
               state_d  = EXLO;
            end else begin
               state_d  = IDLE;
            end
         end
         EXLO: begin
            res_lo_d = alu_c;
            z_lo_d   = alu_flags[2];
            c_lo_d   = alu_flags[1];
            if (wide_q) begin
               state_d = EXHI;
            end else begin
               if (upd_s) begin
                  flags_d = flags_after(opcode_q, alu_flags, flags_q);
               end else begin
                  flags_d = flags_q;
               end
               state_d = is_compare(opcode_q) ? IDLE : WBLO;
            end
         end
         EXHI: begin
            res_hi_d = alu_c;
            if (upd_s) begin
               flags_d = flags_after(opcode_q,
                                     {alu_flags[3], alu_flags[2] & z_lo_q, alu_flags[1:0]},
                                     flags_q);
            end else begin
               flags_d = flags_q;
            end
            state_d = is_compare(opcode_q) ? IDLE : WBLO;
         end
         WBLO: begin
            if (wb_ready) begin
               state_d = wide_q ? WBHI : IDLE;
            end else begin
               state_d = WBLO;
            end
         end
         WBHI: begin
            if (wb_ready) begin
               state_d = IDLE;
            end else begin
               state_d = WBHI;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output decode: ALU drive in EX states, writeback offer in WB states
   always_comb begin
      alu_a      = 32'd0;
      alu_b      = 32'd0;
      alu_carry  = 1'b0;
      alu_opcode = 4'd0;
      wb_valid   = 1'b0;
      wb_rd      = 4'd0;
      wb_data    = 32'd0;
      case (state_q)
         EXLO: begin
            alu_a      = a_q[31:0];
            alu_b      = b_q[31:0];
            alu_carry  = flags_q[1];
            alu_opcode = opcode_q;
         end
         EXHI: begin
            alu_a      = a_q[63:32];
            alu_b      = b_q[63:32];
            alu_carry  = c_lo_q;
            alu_opcode = hi_opcode(opcode_q);
         end
         WBLO: begin
            wb_valid = 1'b1;
            wb_rd    = rd_q;
            wb_data  = res_lo_q;
         end
         WBHI: begin
            wb_valid = 1'b1;
            wb_rd    = rd_q + 4'd1;
            wb_data  = res_hi_q;
         end
         default: begin
            wb_valid = 1'b0;
         end
      endcase
      in_ready = (state_q == IDLE);
      busy     = (state_q != IDLE);
      flags    = flags_q;
   end

endmodule
